// File: rtl/i2c_pkg.sv
// i2c_pkg: shared arbiter state encoding and latched master command
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, OK, FAIL, GAP} arb_state_t;
  typedef struct packed {
    logic       rden;
    logic       wren;
    logic [7:0] addr;
    logic [7:0] wdata;
  } i2c_cmd_t;
endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping around
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] oh_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);
  // scan from the farthest offset down so the nearest hit is written last
  always_comb begin
    oh_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NREQ]) begin
        idx_o = IW'((int'(ptr_i) + i) % NREQ);
        oh_o = NREQ'(1) << ((int'(ptr_i) + i) % NREQ);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin share of one I2C master among NREQ requesters
module i2c_txn_arbiter #(
  parameter int NREQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int GAP = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   req_rden_i,
  input  logic [NREQ-1:0]   req_wren_i,
  input  logic [8*NREQ-1:0] req_addr_i,
  input  logic [8*NREQ-1:0] req_wdata_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [NREQ-1:0]   err_o,
  output logic [7:0]        rdata_o,
  output logic              m_ce_o,
  output logic              m_rden_o,
  output logic              m_wren_o,
  output logic [7:0]        m_addr_o,
  output logic [7:0]        m_wdata_o,
  input  logic              m_ready_i,
  input  logic              m_error_i,
  input  logic [7:0]        m_rdata_i
);
  import i2c_pkg::*;
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);
  arb_state_t      state_q, state_d;
  i2c_cmd_t        cmd_q, cmd_d;
  logic [IW-1:0]   own_q, own_d, ptr_q, ptr_d, pick_idx;
  logic [NREQ-1:0] own_oh_q, own_oh_d, pick_oh;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            ce_q, ce_d, rdy_q, pick_vld, rise;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .oh_o(pick_oh),
    .idx_o(pick_idx),
    .vld_o(pick_vld)
  );

  assign rise = m_ready_i & ~rdy_q;

  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    own_d = own_q;
    own_oh_d = own_oh_q;
    ptr_d = ptr_q;
    timer_d = timer_q;
    gap_d = gap_q;
    rdata_d = rdata_q;
    ce_d = ce_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        own_d = pick_idx;
        own_oh_d = pick_oh;
        state_d = ISSUE;
      end
      ISSUE: begin
        cmd_d.rden = req_rden_i[own_q];
        cmd_d.wren = req_wren_i[own_q] & ~req_rden_i[own_q];
        cmd_d.addr = req_addr_i[own_q*8 +: 8];
        cmd_d.wdata = req_wdata_i[own_q*8 +: 8];
        ce_d = 1'b1;
        timer_d = TW'(TIMEOUT);
        state_d = BUSY;
      end
      // error beats a ready edge; a ready edge beats the last timer tick
      BUSY: begin
        timer_d = timer_q - 1'b1;
        if (m_error_i || (!rise && timer_q == TW'(1))) begin
          ce_d = 1'b0;
          state_d = FAIL;
        end else if (rise) begin
          ce_d = 1'b0;
          rdata_d = cmd_q.rden ? m_rdata_i : 8'h00;
          state_d = OK;
        end
      end
      OK, FAIL: begin
        gap_d = GW'(GAP - 1);
        state_d = i2c_pkg::GAP;
      end
      default: if (gap_q == '0) begin
        ptr_d = (own_q == IW'(NREQ - 1)) ? '0 : own_q + 1'b1;
        state_d = IDLE;
      end else gap_d = gap_q - 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cmd_q <= '0;
      own_q <= '0;
      own_oh_q <= '0;
      ptr_q <= '0;
      timer_q <= '0;
      gap_q <= '0;
      rdata_q <= '0;
      ce_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      own_q <= own_d;
      own_oh_q <= own_oh_d;
      ptr_q <= ptr_d;
      timer_q <= timer_d;
      gap_q <= gap_d;
      rdata_q <= rdata_d;
      ce_q <= ce_d;
      rdy_q <= m_ready_i;
    end
  end

  assign gnt_o = ce_q ? own_oh_q : '0;
  assign done_o = (state_q == OK) ? own_oh_q : '0;
  assign err_o = (state_q == FAIL) ? own_oh_q : '0;
  assign rdata_o = (state_q == OK) ? rdata_q : 8'h00;
  assign m_ce_o = ce_q;
  assign m_rden_o = cmd_q.rden;
  assign m_wren_o = cmd_q.wren;
  assign m_addr_o = cmd_q.addr;
  assign m_wdata_o = cmd_q.wdata;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed and randomized transfers against a round-robin reference model
module tb_i2c_txn_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
  localparam int GP = 2;
  localparam int K_OK = 0;
  localparam int K_NACK = 1;
  localparam int K_TO = 2;
  logic clk = 0;
  logic reset = 1;
  logic [N-1:0] req = '0, req_rden = '0, req_wren = '0;
  logic [8*N-1:0] req_addr = '0, req_wdata = '0;
  logic [N-1:0] gnt, done, err;
  logic [7:0] rdata, m_addr, m_wdata;
  logic m_ce, m_rden, m_wren;
  logic m_ready = 1, m_error = 0;
  logic [7:0] m_rdata = '0;
  int n_checks = 0, n_errors = 0, ptr = 0;

  i2c_txn_arbiter #(.NREQ(N), .TIMEOUT(TO), .GAP(GP)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .req_rden_i(req_rden),
    .req_wren_i(req_wren), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata),
    .m_ce_o(m_ce), .m_rden_o(m_rden), .m_wren_o(m_wren), .m_addr_o(m_addr),
    .m_wdata_o(m_wdata), .m_ready_i(m_ready), .m_error_i(m_error), .m_rdata_i(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic set_cmd(input int i, input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    req_rden[i] = rd;
    req_wren[i] = wr;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  task automatic rand_cmd(input int i);
    set_cmd(i, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic run_xfer(input int kind, input int lat, input bit drop, input bit hold, input bit chk_lat, input int rdv);
    int w, n;
    logic [N-1:0] oh;
    logic [17:0] cmd;
    logic [7:0] exp_rd;
    w = pick(req, ptr);
    if (w < 0) begin
      check("model_req", 0, 1);
      return;
    end
    oh = N'(1 << w);
    cmd = {req_addr[w*8 +: 8], req_wdata[w*8 +: 8], req_rden[w], req_wren[w] & ~req_rden[w]};
    n = 0;
    while (gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gnt", gnt, oh);
    if (gnt == '0) return;
    if (chk_lat) check("latency", n, 2);
    check("cmd", {m_ce, m_addr, m_wdata, m_rden, m_wren}, {1'b1, cmd});
    m_ready = 0;
    if (drop) req[w] = 0;
    if (kind == K_TO) begin
      repeat (TO - 1) begin
        @(negedge clk);
        check("to_busy", {m_ce, gnt, done, err}, {1'b1, oh, 8'h00});
      end
      @(negedge clk);
      check("to_err", {m_ce, gnt, done, err, rdata}, {1'b0, 4'h0, 4'h0, oh, 8'h00});
    end else begin
      repeat (lat) begin
        @(negedge clk);
        check("busy", {m_ce, gnt, done, err, m_addr, m_wdata, m_rden, m_wren}, {1'b1, oh, 8'h00, cmd});
      end
      if (kind == K_NACK) begin
        m_error = 1;
        exp_rd = 8'h00;
      end else begin
        m_ready = 1;
        m_rdata = (rdv < 0) ? 8'($urandom) : 8'(rdv);
        exp_rd = cmd[1] ? m_rdata : 8'h00;
      end
      @(negedge clk);
      check("resp", {m_ce, gnt, done, err, rdata},
            {1'b0, 4'h0, (kind == K_OK) ? oh : 4'h0, (kind == K_NACK) ? oh : 4'h0, exp_rd});
    end
    m_error = 0;
    m_ready = 1;
    if (!hold) req[w] = 0;
    ptr = (w + 1) % N;
    repeat (GP) begin
      @(negedge clk);
      check("gap", {m_ce, gnt, done, err, rdata}, 0);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset", {gnt, done, err, rdata, m_ce, m_rden, m_wren, m_addr, m_wdata}, 0);
    reset = 0;
    set_cmd(0, 0, 1, 8'h45, 8'hA5);
    req = 4'b0001;
    run_xfer(K_OK, 3, 0, 0, 1, -1);
    set_cmd(2, 1, 0, 8'h81, 8'h00);
    req = 4'b0100;
    run_xfer(K_OK, 4, 0, 0, 0, 8'h3C);
    for (int i = 1; i < N; i++) rand_cmd(i);
    req = 4'b1110;
    run_xfer(K_OK, 2, 0, 0, 0, -1);
    run_xfer(K_NACK, 5, 0, 0, 0, -1);
    run_xfer(K_OK, 1, 0, 0, 0, -1);
    set_cmd(0, 0, 0, 8'hC3, 8'h5A);
    req = 4'b0001;
    run_xfer(K_TO, 0, 0, 0, 0, -1);
    rand_cmd(0);
    req = 4'b0001;
    k = 0;
    while (gnt == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_gnt", gnt, 4'b0001);
    m_ready = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    check("rst_busy", {m_ce, gnt, done, err, rdata}, 0);
    req = '0;
    @(negedge clk);
    reset = 0;
    m_ready = 1;
    ptr = 0;
    rand_cmd(3);
    req = 4'b1000;
    run_xfer(K_OK, 3, 0, 0, 1, -1);
    for (int i = 0; i < N; i++) rand_cmd(i);
    req = 4'b1111;
    repeat (5) run_xfer(K_OK, 2, 0, 1, 0, -1);
    req = '0;
    repeat (40) begin
      for (int i = 0; i < N; i++) if (!req[i] && $urandom_range(0, 1) == 1) begin
        rand_cmd(i);
        req[i] = 1;
      end
      if (req == '0) begin
        rand_cmd(0);
        req[0] = 1;
      end
      k = $urandom_range(0, 9);
      run_xfer((k < 2) ? K_NACK : (k == 2) ? K_TO : K_OK, $urandom_range(1, 8),
               $urandom_range(0, 3) == 0, 0, 0, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
